uart_io_ctrl: RTL and testbench

Processor-side I/O controller that sits between `processor_top`'s IO port bus and `rs232_uart`. It decodes IO strobes and buffers processor writes in a small TX FIFO. It drains that FIFO into the UART under the UART's `tx_buffer_full` back-pressure, and pre-fetches one RX byte into a holding register. Firmware can therefore write bursts without polling port 0x03 before every byte.

---
 rtl/uart_io_pkg.sv | 16 +
 rtl/sync_fifo.sv | 70 +++++++
 rtl/uart_io_ctrl.sv | 134 +++++++++++++
 tb/tb_uart_io_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_io_pkg.sv
// Shared constants for the processor-side UART I/O controller:
// default port IDs and the TX drain state encoding.
package uart_io_pkg;

    localparam logic [7:0] PORT_DATA_ID    = 8'h01;
    localparam logic [7:0] PORT_RX_STAT_ID = 8'h02;
    localparam logic [7:0] PORT_TX_STAT_ID = 8'h03;
    localparam logic [7:0] PORT_STAT_ID    = 8'h04;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } drain_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small register-based synchronous FIFO with occupancy count.
// Pushes when full and pops when empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
            end
        end
    end

endmodule

// File: rtl/uart_io_ctrl.sv
// IO-port front end for the UART: buffers processor writes in a TX FIFO,
// drains them under UART back-pressure, and prefetches one RX byte.
module uart_io_ctrl
    import uart_io_pkg::*;
#(
    parameter int         TX_DEPTH     = 4,
    parameter logic [7:0] PORT_DATA    = PORT_DATA_ID,
    parameter logic [7:0] PORT_RX_STAT = PORT_RX_STAT_ID,
    parameter logic [7:0] PORT_TX_STAT = PORT_TX_STAT_ID,
    parameter logic [7:0] PORT_STAT    = PORT_STAT_ID
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] IO_port_ID,
    input  logic [7:0] IO_write_data,
    input  logic       IO_write_strobe,
    input  logic       IO_read_strobe,
    output logic [7:0] IO_read_data,
    output logic [7:0] uart_tx_data,
    output logic       uart_write,
    input  logic       uart_tx_full,
    input  logic [7:0] uart_rx_data,
    input  logic       uart_rx_present,
    output logic       uart_rx_ack,
    output logic       tx_busy
);

    localparam int CW = $clog2(TX_DEPTH) + 1;

    drain_state_t  state_q, state_d;
    logic          uart_write_q, uart_write_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic [7:0]    rx_hold_q, rx_hold_d;
    logic          tx_drop_q, tx_drop_d;

    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]    fifo_head;
    logic [CW-1:0] fifo_count;
    logic [3:0]    count4;
    logic          wr_data_hit, rd_data_hit, rd_stat_hit;

    assign wr_data_hit = IO_write_strobe && (IO_port_ID == PORT_DATA);
    assign rd_data_hit = IO_read_strobe && (IO_port_ID == PORT_DATA);
    assign rd_stat_hit = IO_read_strobe && (IO_port_ID == PORT_STAT);
    // Full is sampled before this cycle's pop, so a coincident pop never rescues a push.
    assign fifo_push   = wr_data_hit && !fifo_full;
    assign count4      = 4'(fifo_count);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (IO_write_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign fifo_pop     = (state_q == ST_ISSUE);
    assign uart_write   = uart_write_q;
    assign uart_tx_data = tx_data_q;
    assign tx_busy      = !fifo_empty || (state_q != ST_IDLE);
    assign uart_rx_ack  = !rx_valid_q && uart_rx_present;

    always_comb begin
        state_d      = state_q;
        uart_write_d = 1'b0;
        tx_data_d    = 8'h00;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && !uart_tx_full) begin
                    state_d      = ST_ISSUE;
                    uart_write_d = 1'b1;
                    tx_data_d    = fifo_head;
                end
            end
            ST_ISSUE: state_d = ST_GAP;
            ST_GAP:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        rx_valid_d = rx_valid_q;
        rx_hold_d  = rx_hold_q;
        if (uart_rx_ack) begin
            rx_valid_d = 1'b1;
            rx_hold_d  = uart_rx_data;
        end else if (rd_data_hit) begin
            rx_valid_d = 1'b0;
        end

        // A drop landing on the clearing read wins, so no overflow goes unreported.
        tx_drop_d = (tx_drop_q && !rd_stat_hit) || (wr_data_hit && fifo_full);
    end

    always_comb begin
        IO_read_data = 8'h00;
        if (IO_read_strobe) begin
            if (IO_port_ID == PORT_DATA) begin
                IO_read_data = rx_valid_q ? rx_hold_q : 8'h00;
            end else if (IO_port_ID == PORT_RX_STAT) begin
                IO_read_data = {7'b0, rx_valid_q};
            end else if (IO_port_ID == PORT_TX_STAT) begin
                IO_read_data = {7'b0, fifo_full};
            end else if (IO_port_ID == PORT_STAT) begin
                IO_read_data = {tx_drop_q, 3'b000, count4};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            uart_write_q <= 1'b0;
            tx_data_q    <= 8'h00;
            rx_valid_q   <= 1'b0;
            rx_hold_q    <= 8'h00;
            tx_drop_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            uart_write_q <= uart_write_d;
            tx_data_q    <= tx_data_d;
            rx_valid_q   <= rx_valid_d;
            rx_hold_q    <= rx_hold_d;
            tx_drop_q    <= tx_drop_d;
        end
    end

endmodule

// File: tb/tb_uart_io_ctrl.sv
// Directed scoreboard bench for uart_io_ctrl: stimulus queues expected
// TX bytes and read values; a negedge monitor compares them as they appear.
module tb_uart_io_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] IO_port_ID = 8'h00;
    logic [7:0] IO_write_data = 8'h00;
    logic       IO_write_strobe = 1'b0;
    logic       IO_read_strobe = 1'b0;
    logic [7:0] IO_read_data;
    logic [7:0] uart_tx_data;
    logic       uart_write;
    logic       uart_tx_full = 1'b0;
    logic [7:0] uart_rx_data = 8'h00;
    logic       uart_rx_present = 1'b0;
    logic       uart_rx_ack;
    logic       tx_busy;

    typedef struct {
        logic [7:0] port;
        logic [7:0] data;
    } rd_exp_t;

    logic [7:0] tx_q[$];
    rd_exp_t    rd_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         ack_count = 0;

    uart_io_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .IO_port_ID      (IO_port_ID),
        .IO_write_data   (IO_write_data),
        .IO_write_strobe (IO_write_strobe),
        .IO_read_strobe  (IO_read_strobe),
        .IO_read_data    (IO_read_data),
        .uart_tx_data    (uart_tx_data),
        .uart_write      (uart_write),
        .uart_tx_full    (uart_tx_full),
        .uart_rx_data    (uart_rx_data),
        .uart_rx_present (uart_rx_present),
        .uart_rx_ack     (uart_rx_ack),
        .tx_busy         (tx_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Monitor: compares every presented read and UART write against the queues.
    always @(negedge clk) begin
        if (IO_read_strobe) begin
            n_cmp++;
            if (rd_q.size() == 0) begin
                n_bad++;
                $display("FAIL rd_unexpected: port %h got %h, none expected", IO_port_ID, IO_read_data);
            end else begin
                rd_exp_t e;
                e = rd_q.pop_front();
                if (IO_read_data !== e.data || IO_port_ID !== e.port) begin
                    n_bad++;
                    $display("FAIL rd_port_%h: got %h, expected %h", e.port, IO_read_data, e.data);
                end else begin
                    $display("read  port %h -> %h ok", e.port, IO_read_data);
                end
            end
        end
        if (uart_write) begin
            n_cmp++;
            if (tx_q.size() == 0) begin
                n_bad++;
                $display("FAIL tx_unexpected: got byte %h, none expected", uart_tx_data);
            end else begin
                logic [7:0] e;
                e = tx_q.pop_front();
                if (uart_tx_data !== e) begin
                    n_bad++;
                    $display("FAIL tx_byte: got %h, expected %h", uart_tx_data, e);
                end else begin
                    $display("uart  tx %h at cycle %0d ok", uart_tx_data, cyc);
                end
            end
        end
        if (uart_rx_ack) ack_count++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("check %s = %0h ok", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic io_write(input logic [7:0] port, input logic [7:0] data);
        IO_port_ID      = port;
        IO_write_data   = data;
        IO_write_strobe = 1'b1;
        tick();
        IO_write_strobe = 1'b0;
    endtask

    task automatic io_read(input logic [7:0] port, input logic [7:0] exp);
        rd_exp_t e;
        e.port = port;
        e.data = exp;
        rd_q.push_back(e);
        IO_port_ID     = port;
        IO_read_strobe = 1'b1;
        tick();
        IO_read_strobe = 1'b0;
    endtask

    task automatic wait_write(output int at);
        bit got = 0;
        at = -1;
        for (int i = 0; i < 30 && !got; i++) begin
            tick();
            if (uart_write) begin
                got = 1;
                at  = cyc;
            end
        end
        if (!got) chk("wait_write_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            tick();
            if (!tx_busy) done = 1;
        end
        if (!done) chk("wait_idle_timeout", 0, 1);
    endtask

    initial begin
        int t0, t1;

        // Reset state
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_uart_write", uart_write, 0);
        chk("rst_rx_ack", uart_rx_ack, 0);
        chk("rst_tx_busy", tx_busy, 0);
        chk("rst_tx_data", uart_tx_data, 0);
        chk("idle_read_data", IO_read_data, 0);
        io_read(8'h04, 8'h00);
        io_read(8'h02, 8'h00);
        io_read(8'h03, 8'h00);
        io_write(8'h07, 8'hEE);
        io_read(8'h07, 8'h00);
        io_read(8'h04, 8'h00);

        // Single byte: uart_write two cycles after the push
        tx_q.push_back(8'h41);
        io_write(8'h01, 8'h41);
        chk("single_not_yet", uart_write, 0);
        tick();
        chk("single_write", uart_write, 1);
        chk("single_data", uart_tx_data, 8'h41);
        tick();
        chk("single_gap_busy", tx_busy, 1);
        tick();
        chk("single_busy_fall", tx_busy, 0);

        // Overflow with UART held full
        uart_tx_full = 1'b1;
        for (int i = 0; i < 5; i++) io_write(8'h01, 8'h10 + 8'(i));
        io_read(8'h03, 8'h01);
        io_read(8'h04, 8'h84);
        io_read(8'h04, 8'h04);
        for (int i = 0; i < 4; i++) tx_q.push_back(8'h10 + 8'(i));
        uart_tx_full = 1'b0;
        wait_write(t0);
        for (int i = 0; i < 3; i++) begin
            wait_write(t1);
            chk("drain_spacing", t1 - t0, 3);
            t0 = t1;
        end
        wait_idle();

        // Back-pressure asserted right after each issue
        uart_tx_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            io_write(8'h01, 8'h20 + 8'(i));
            tx_q.push_back(8'h20 + 8'(i));
        end
        for (int b = 0; b < 3; b++) begin
            uart_tx_full = 1'b0;
            wait_write(t0);
            uart_tx_full = 1'b1;
            for (int i = 0; i < 4; i++) begin
                tick();
                chk("bp_hold_no_write", uart_write, 0);
            end
        end
        uart_tx_full = 1'b0;
        wait_idle();
        io_read(8'h04, 8'h00);

        // RX prefetch and pop
        uart_rx_data    = 8'h5A;
        uart_rx_present = 1'b1;
        #1;
        chk("rx_ack_now", uart_rx_ack, 1);
        tick();
        chk("rx_ack_once", uart_rx_ack, 0);
        tick();
        uart_rx_present = 1'b0;
        uart_rx_data    = 8'h00;
        io_read(8'h02, 8'h01);
        io_read(8'h01, 8'h5A);
        io_read(8'h02, 8'h00);
        io_read(8'h01, 8'h00);
        chk("rx_ack_count", ack_count, 1);

        // Push to full FIFO on the ISSUE cycle is dropped
        uart_tx_full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            io_write(8'h01, 8'h30 + 8'(i));
            tx_q.push_back(8'h30 + 8'(i));
        end
        uart_tx_full = 1'b0;
        tick();
        chk("conc_issue", uart_write, 1);
        io_write(8'h01, 8'h99);
        io_read(8'h04, 8'h83);
        wait_idle();
        io_read(8'h04, 8'h00);

        // Reset in the middle of ISSUE
        uart_tx_full = 1'b1;
        io_write(8'h01, 8'h55);
        io_write(8'h01, 8'h66);
        uart_rx_data    = 8'h77;
        uart_rx_present = 1'b1;
        tick();
        uart_rx_present = 1'b0;
        uart_tx_full    = 1'b0;
        wait_write(t0);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_mid_issue_write", uart_write, 0);
        chk("rst_mid_issue_busy", tx_busy, 0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        io_read(8'h04, 8'h00);
        io_read(8'h02, 8'h00);
        io_read(8'h01, 8'h00);
        repeat (8) tick();
        chk("rst_no_tx_after", tx_busy, 0);
        chk("ack_total", ack_count, 2);
        chk("tx_queue_drained", tx_q.size(), 0);
        chk("rd_queue_drained", rd_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
